vram_access_responder: RTL
==========================

Name: vram_access_responder

Overview:
- Memory-side end of the VDP VRAM address bus.
- Samples the arbiter's byte-addressed request (IRAMADR, PRAMWE_N, PRAM_WR_SIZE, PRAMDBO_8/16/32) at fixed DOTSTATE slots.
- Converts each request into one 32-bit-word transaction on a req/ack memory port with byte enables.
- Returns read data on 8/16/32-bit lanes to the drawing, sprite, CPU and command readers.
- Sits between the VRAM arbiter and the BSRAM/SDRAM wrapper.

Parameters:
- SLOT_B_EN, 1, when 1, also sample a read request at DOTSTATE 2'b00 (second draw fetch for GRAPHIC6/7); when 0, only the 2'b11 slot is sampled.
- ADDR_W, 19, byte address width; memory word address is ADDR_W-2 bits.

Ports:
- CLK21M  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- DOTSTATE  in  2  dot phase from the VDP timing generator
- IRAMADR  in  19  byte address from the arbiter
- PRAMWE_N  in  1  0 = write, 1 = read
- PRAM_WR_SIZE  in  2  write width code (package constants)
- PRAMDBO_8  in  8  write data, 8-bit access
- PRAMDBO_16  in  16  write data, 16-bit access
- PRAMDBO_32  in  32  write data, 32-bit access
- PRAMDBI_8  out  8  read byte selected by the captured address
- PRAMDBI_16  out  16  read halfword selected by the captured address
- PRAMDBI_32  out  32  read word
- rd_data_valid  out  1  one-cycle pulse when the PRAMDBI_* outputs update
- mem_req  out  1  transaction request, level
- mem_we  out  1  transaction is a write
- mem_addr  out  17  word address (IRAMADR[18:2])
- mem_be  out  4  byte enables; bit n enables bits [8n+7:8n]
- mem_wdata  out  32  write data
- mem_ack  in  1  one-cycle completion strobe; mem_rdata valid on this cycle for reads
- mem_rdata  in  32  read data
- overrun_count  out  8  saturating count of dropped slots

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0, state IDLE, captured address 0.
- Slot detection:
  - Slot A: DOTSTATE==2'b11; a read or write is sampled.
  - Slot B: DOTSTATE==2'b00 with SLOT_B_EN=1; a read is sampled only if PRAMWE_N=1, else the slot is ignored.
  - On a slot, all request inputs are latched into a request register in the same cycle.
- State machine IDLE -> BUSY -> IDLE:
  - IDLE + slot: latch the request; mem_req=1 from the next cycle; state becomes BUSY.
  - BUSY: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack.
  - BUSY + mem_ack: mem_req drops the next cycle.
    - Read: capture mem_rdata; rd_data_valid pulses the cycle after mem_ack, together with the updated PRAMDBI_*.
    - Write: no data update and no pulse.
  - Same-cycle mem_ack and slot: the new request is accepted with no overrun; mem_req stays high with the new fields from the next cycle.
  - BUSY, no ack, slot arrives: the slot is dropped; overrun_count increments and saturates at 255; the in-flight transaction is unaffected.
- Minimum latency: slot at cycle T, mem_req high at T+1, earliest mem_ack T+1, rd_data_valid at T+2.
- Write lane mapping (a = IRAMADR[1:0]):
  - 8-bit: mem_be = 1<<a; mem_wdata = {4{PRAMDBO_8}}.
  - 16-bit: mem_be = a[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{PRAMDBO_16}}; a[0] ignored.
  - 32-bit: mem_be = 4'b1111; mem_wdata = PRAMDBO_32; a ignored.
  - Reserved size 2'b11: treated as 8-bit.
- Reads: mem_be = 4'b1111 and mem_wdata = 0. The PRAMDBO_* inputs are don't-care, since the arbiter may drive them Z.
- Read lane selection uses the latched address:
  - PRAMDBI_8 = byte a of the captured word.
  - PRAMDBI_16 = upper half if a[1], else lower half.
  - PRAMDBI_32 = the full word.
- All PRAMDBI_* hold their value until the next read completes. Writes never change them.
- Address wrap: none; mem_addr is IRAMADR[18:2] verbatim.
- mem_ack while IDLE: ignored.
- Reset mid-transaction: mem_req falls immediately and the pending access is discarded. The memory wrapper must tolerate an abandoned request.

Decomposition:
- Shared package vdp_vram_pkg:
  - MEMORY_WIDTH_8=2'b00, MEMORY_WIDTH_16=2'b01, MEMORY_WIDTH_32=2'b10.
  - DOTSTATE slot constants DOT_SLOT_A=2'b11 and DOT_SLOT_B=2'b00.
  - Typedef vram_req_t {addr[18:0], we, size[1:0], d8, d16, d32}.
- One sub-module, vram_lane_mux: combinational byte-enable/write-data generator plus read-lane selector, reused by the command engine's VRAM model.

Test Plan:
- 8-bit write at IRAMADR=19'h00005, data 8'hA5, slot A -> mem_addr=17'h00001, mem_be=4'b0010, mem_wdata=32'hA5A5A5A5, mem_we=1; no rd_data_valid.
- 32-bit read at 19'h00010, mem_rdata=32'h11223344 with ack 2 cycles after mem_req -> rd_data_valid one cycle after ack; PRAMDBI_32=32'h11223344, PRAMDBI_16=16'h3344, PRAMDBI_8=8'h44.
- 16-bit write at 19'h00003 (a[0]=1), data 16'hBEEF -> mem_be=4'b1100, mem_wdata=32'hBEEFBEEF.
- mem_ack withheld for 6 cycles across two slots -> overrun_count=1; the original transaction's fields stay stable until ack; after 300 forced overruns, count=255.
- SLOT_B_EN=1, read at DOTSTATE 2'b00, ack coinciding with the next slot A -> both transactions served, overrun_count=0; with PRAMWE_N=0 at slot B, no mem_req.
- RESET_N pulsed low while mem_req=1 -> mem_req=0 asynchronously; all outputs 0; a later mem_ack is ignored.

Source files
------------

// File: rtl/vdp_vram_pkg.sv
// Shared VRAM access definitions: write-width codes, dot-phase slots and the
// latched request record used by the VRAM access responder.
package vdp_vram_pkg;

  localparam logic [1:0] MEMORY_WIDTH_8  = 2'b00;
  localparam logic [1:0] MEMORY_WIDTH_16 = 2'b01;
  localparam logic [1:0] MEMORY_WIDTH_32 = 2'b10;

  localparam logic [1:0] DOT_SLOT_A = 2'b11;
  localparam logic [1:0] DOT_SLOT_B = 2'b00;

  typedef struct packed {
    logic [18:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
  } vram_req_t;

endpackage

// File: rtl/vram_lane_mux.sv
// Byte-lane steering between byte-addressed VDP accesses and a 32-bit word
// memory: byte enables and replicated write data on the way out, byte and
// halfword selection on the way back in.
module vram_lane_mux
  import vdp_vram_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [7:0]  i_d8,
  input  logic [15:0] i_d16,
  input  logic [31:0] i_d32,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_rd_addr_lo,
  input  logic [31:0] i_rword,
  output logic [7:0]  o_rd8,
  output logic [15:0] o_rd16
);

  // Write enables/data; reads fetch the whole word and drive no data.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = 32'h0;
    if (i_we) begin
      case (i_size)
        MEMORY_WIDTH_16: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_d16}};
        end
        MEMORY_WIDTH_32: begin
          o_be    = 4'b1111;
          o_wdata = i_d32;
        end
        // 8-bit and the reserved code both take the byte path
        default: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_d8}};
        end
      endcase
    end
  end

  // Read lane selection from the word returned by memory.
  always_comb begin
    o_rd8 = 8'h0;
    case (i_rd_addr_lo)
      2'd0:    o_rd8 = i_rword[7:0];
      2'd1:    o_rd8 = i_rword[15:8];
      2'd2:    o_rd8 = i_rword[23:16];
      default: o_rd8 = i_rword[31:24];
    endcase
    o_rd16 = i_rd_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

endmodule

// File: rtl/vram_access_responder.sv
// Memory-side end of the VDP VRAM bus: samples arbiter requests at fixed dot
// slots, issues one word transaction per request on a req/ack port, and
// returns read data on 8/16/32-bit lanes.
module vram_access_responder
  import vdp_vram_pkg::*;
#(
  parameter logic SLOT_B_EN = 1'b1,
  parameter int   ADDR_W    = 19
) (
  input  logic              CLK21M,
  input  logic              RESET_N,
  input  logic [1:0]        DOTSTATE,
  input  logic [ADDR_W-1:0] IRAMADR,
  input  logic              PRAMWE_N,
  input  logic [1:0]        PRAM_WR_SIZE,
  input  logic [7:0]        PRAMDBO_8,
  input  logic [15:0]       PRAMDBO_16,
  input  logic [31:0]       PRAMDBO_32,
  output logic [7:0]        PRAMDBI_8,
  output logic [15:0]       PRAMDBI_16,
  output logic [31:0]       PRAMDBI_32,
  output logic              rd_data_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        overrun_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] r_state;
  vram_req_t  r_req;
  logic [7:0]  r_pd8;
  logic [15:0] r_pd16;
  logic [31:0] r_pd32;
  logic        r_rd_valid;
  logic [7:0]  r_ovr;

  logic        w_busy;
  logic        w_slot;
  logic        w_accept;
  logic        w_done;
  vram_req_t   w_new_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_rd8;
  logic [15:0] w_rd16;

  assign w_busy = (r_state == ST_BUSY);

  // Slot B only carries reads; a write presented there is ignored.
  assign w_slot = (DOTSTATE == DOT_SLOT_A) ||
                  (SLOT_B_EN && (DOTSTATE == DOT_SLOT_B) && PRAMWE_N);

  // A slot is taken when idle, or when the in-flight access completes this cycle.
  assign w_done   = w_busy && mem_ack;
  assign w_accept = w_slot && (!w_busy || mem_ack);

  // Write data is masked on reads: the arbiter may float the data bus then.
  assign w_new_req.addr = IRAMADR;
  assign w_new_req.we   = ~PRAMWE_N;
  assign w_new_req.size = PRAM_WR_SIZE;
  assign w_new_req.d8   = PRAMWE_N ? 8'h0  : PRAMDBO_8;
  assign w_new_req.d16  = PRAMWE_N ? 16'h0 : PRAMDBO_16;
  assign w_new_req.d32  = PRAMWE_N ? 32'h0 : PRAMDBO_32;

  vram_lane_mux u_lane_mux (
    .i_addr_lo    (r_req.addr[1:0]),
    .i_we         (r_req.we),
    .i_size       (r_req.size),
    .i_d8         (r_req.d8),
    .i_d16        (r_req.d16),
    .i_d32        (r_req.d32),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_rd_addr_lo (r_req.addr[1:0]),
    .i_rword      (mem_rdata),
    .o_rd8        (w_rd8),
    .o_rd16       (w_rd16)
  );

  // Request register and IDLE/BUSY sequencing.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
    end else if (w_accept) begin
      r_state <= ST_BUSY;
      r_req   <= w_new_req;
    end else if (w_done) begin
      r_state <= ST_IDLE;
    end
  end

  // Capture read data at ack using the address of the completing access.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pd8      <= 8'h0;
      r_pd16     <= 16'h0;
      r_pd32     <= 32'h0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_done && !r_req.we) begin
        r_pd8      <= w_rd8;
        r_pd16     <= w_rd16;
        r_pd32     <= mem_rdata;
        r_rd_valid <= 1'b1;
      end
    end
  end

  // Count slots dropped while an access is still outstanding, saturating.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ovr <= 8'h0;
    end else if (w_slot && w_busy && !mem_ack && (r_ovr != 8'hFF)) begin
      r_ovr <= r_ovr + 8'd1;
    end
  end

  // Memory port is driven from the request register only while busy.
  assign mem_req       = w_busy;
  assign mem_we        = w_busy && r_req.we;
  assign mem_addr      = w_busy ? r_req.addr[ADDR_W-1:2] : '0;
  assign mem_be        = w_busy ? w_be : 4'b0000;
  assign mem_wdata     = w_busy ? w_wdata : 32'h0;
  assign PRAMDBI_8     = r_pd8;
  assign PRAMDBI_16    = r_pd16;
  assign PRAMDBI_32    = r_pd32;
  assign rd_data_valid = r_rd_valid;
  assign overrun_count = r_ovr;

endmodule
